cfg_chain_ctrl: RTL and testbench

//  Sequences serial loading of the FPGA configuration shift chain on prog_clk.

---
 rtl/cfg_chain_ctrl_if.sv | 21 ++
 rtl/cfg_chain_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cfg_chain_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_chain_ctrl_if.sv
// Bitstream source handshake between a word supplier and the chain loader.
// A word transfers on a prog_clk edge where cfg_valid and cfg_ready are both high.
interface cfg_chain_ctrl_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/cfg_chain_ctrl.sv
// Serial loader for the FPGA configuration shift chain, with an optional
// read-back pass that CRC-compares the bits leaving the chain against those sent.
module cfg_chain_ctrl #(
    parameter int          CHAIN_LEN = 64,
    parameter int          WORD_W    = 8,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
    input  logic             prog_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             verify_en,
    cfg_chain_ctrl_if.slave  src,
    output logic             fpga_head,
    output logic             chain_clk_en,
    input  logic             fpga_tail,
    output logic             busy,
    output logic             done,
    output logic             crc_err
);

    localparam int              CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam int              WB_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(CHAIN_LEN);
    localparam logic [WB_W-1:0]  LAST_BIT = WB_W'(WORD_W - 1);
    localparam logic [15:0]      CRC_POLY = 16'h1021;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        PASS_END,
        CHECK,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] shifter;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_inc;
    logic [WB_W-1:0]   word_bit;
    logic              word_end;
    logic              pass;
    logic              verify_q;
    logic              edge_d;
    logic [15:0]       crc_in;
    logic [15:0]       crc_out;

    // Bit-serial CRC-16-CCITT, one message bit per call, MSB-first.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb       = crc[15] ^ bit_in;
        crc_step = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

    assign bit_cnt_inc = bit_cnt + CNT_W'(1);
    assign word_end    = (word_bit == LAST_BIT);
    assign fpga_head   = shifter[WORD_W-1];

    always_comb begin
        state_next    = state;
        src.cfg_ready = 1'b0;
        chain_clk_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                src.cfg_ready = 1'b1;
                if (src.cfg_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                chain_clk_en = 1'b1;
                if (word_end) begin
                    state_next = (bit_cnt_inc < LEN_C) ? FETCH : PASS_END;
                end
            end
            PASS_END: begin
                if (pass) begin
                    state_next = CHECK;
                end else if (verify_q) begin
                    state_next = FETCH;
                end else begin
                    state_next = DONE;
                end
            end
            CHECK: begin
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shifter  <= '0;
            bit_cnt  <= '0;
            word_bit <= '0;
            pass     <= 1'b0;
            verify_q <= 1'b0;
            edge_d   <= 1'b0;
            crc_in   <= '0;
            crc_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            crc_err  <= 1'b0;
        end else begin
            state  <= state_next;
            // The tail register moves on the chain edge, so the fresh tail bit
            // is only valid one prog_clk cycle after each read-back edge.
            edge_d <= (state == SHIFT) && pass;
            if (edge_d) begin
                crc_out <= crc_step(crc_out, fpga_tail);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        verify_q <= verify_en;
                        pass     <= 1'b0;
                        bit_cnt  <= '0;
                        word_bit <= '0;
                        crc_in   <= CRC_INIT;
                        crc_out  <= CRC_INIT;
                        done     <= 1'b0;
                        crc_err  <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (src.cfg_valid) begin
                        shifter  <= src.cfg_data;
                        word_bit <= '0;
                    end
                end
                SHIFT: begin
                    shifter  <= {shifter[WORD_W-2:0], 1'b0};
                    bit_cnt  <= bit_cnt_inc;
                    word_bit <= word_bit + WB_W'(1);
                    if (!pass) begin
                        crc_in <= crc_step(crc_in, shifter[WORD_W-1]);
                    end
                end
                PASS_END: begin
                    if (!pass && verify_q) begin
                        pass    <= 1'b1;
                        bit_cnt <= '0;
                    end else if (!pass) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                CHECK: begin
                    crc_err <= (crc_in != crc_out);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_chain_ctrl.sv
// Bench for cfg_chain_ctrl: behavioural chain on the gated clock, a word source
// fed from a queue, and a scoreboard checked whenever done rises.
module tb_cfg_chain_ctrl;

    localparam int CHAIN_LEN = 64;
    localparam int WORD_W    = 8;
    localparam int NWORDS    = CHAIN_LEN / WORD_W;
    localparam logic [63:0] T1S = 64'hA501020304050607;

    typedef struct {
        logic [63:0] chain;
        logic        err;
        int          edges;
        int          hs;
    } exp_t;

    logic prog_clk = 1'b0;
    logic reset    = 1'b1;
    logic start    = 1'b0;
    logic verify_en = 1'b0;
    logic fpga_head, chain_clk_en, busy, done, crc_err;
    logic fpga_tail;

    cfg_chain_ctrl_if #(.WORD_W(WORD_W)) src ();

    cfg_chain_ctrl #(
        .CHAIN_LEN(CHAIN_LEN),
        .WORD_W   (WORD_W),
        .CRC_INIT (16'hFFFF)
    ) dut (
        .prog_clk    (prog_clk),
        .reset       (reset),
        .start       (start),
        .verify_en   (verify_en),
        .src         (src),
        .fpga_head   (fpga_head),
        .chain_clk_en(chain_clk_en),
        .fpga_tail   (fpga_tail),
        .busy        (busy),
        .done        (done),
        .crc_err     (crc_err)
    );

    always #5 prog_clk = ~prog_clk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference CRC over the whole 64-bit bitstream, first bit = bit 63.
    function automatic logic [15:0] crc_ref(input logic [63:0] s);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 63; i >= 0; i--) begin
            if (c[15] ^ s[i]) c = (c << 1) ^ 16'h1021;
            else              c = c << 1;
        end
        return c;
    endfunction

    // Behavioural chain: 64 stages plus tail register, advancing on gated edges
    logic [63:0] chain = '0;
    logic        tail  = 1'b0;
    int          edge_cnt = 0;
    int          hs_cnt = 0;
    int          edges_total = 0;
    bit          hs_flag = 1'b0;
    bit          fault_arm = 1'b0;
    int          fault_bit = 0;
    assign fpga_tail = tail;

    always @(posedge prog_clk) begin
        logic [63:0] nxt;
        hs_flag = src.cfg_valid && src.cfg_ready;
        if (start && !busy) begin
            edge_cnt = 0;
            hs_cnt   = 0;
        end
        if (hs_flag) hs_cnt++;
        if (chain_clk_en) begin
            nxt = {chain[62:0], fpga_head};
            edge_cnt++;
            edges_total++;
            if (fault_arm && edge_cnt == CHAIN_LEN) nxt[fault_bit] = ~nxt[fault_bit];
            tail  <= chain[63];
            chain <= nxt;
        end
    end

    // Word source
    logic [WORD_W-1:0] src_q[$];
    bit hold = 1'b0;
    bit gaps = 1'b0;

    initial begin
        src.cfg_valid = 1'b0;
        src.cfg_data  = '0;
        forever begin
            @(posedge prog_clk);
            #1;
            if (hs_flag && src_q.size() > 0) void'(src_q.pop_front());
            src.cfg_valid = (src_q.size() > 0) && !hold && !(gaps && $urandom_range(0, 3) == 0);
            src.cfg_data  = (src_q.size() > 0) ? src_q[0] : '0;
        end
    end

    // Scoreboard monitor
    exp_t sb[$];

    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge prog_clk);
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("chain_contents", chain, e.chain);
                    check("crc_err", 64'(crc_err), 64'(e.err));
                    check("edge_count", 64'(edge_cnt), 64'(e.edges));
                    check("handshakes", 64'(hs_cnt), 64'(e.hs));
                    check("busy_at_done", 64'(busy), 64'(0));
                end
            end
            done_prev = done;
        end
    end

    task automatic push_words(input logic [63:0] s);
        for (int w = 0; w < NWORDS; w++) src_q.push_back(s[63 - WORD_W*w -: WORD_W]);
    endtask

    task automatic run_load(input logic [63:0] s, input bit verify, input bit fault,
                            input int fbit, input bit rgaps, input bit stall, input bit busy_start);
        exp_t e;
        int   t;
        logic [63:0] pass1;
        push_words(s);
        if (verify) push_words(s);
        fault_arm = fault;
        fault_bit = fbit;
        gaps      = rgaps;
        pass1     = fault ? (s ^ (64'd1 << fbit)) : s;
        e.chain   = s;
        e.err     = verify && (crc_ref(s) != crc_ref(pass1));
        e.edges   = verify ? 2*CHAIN_LEN : CHAIN_LEN;
        e.hs      = verify ? 2*NWORDS : NWORDS;
        sb.push_back(e);

        @(negedge prog_clk);
        start     = 1'b1;
        verify_en = verify;
        check("ready_low_in_idle", 64'(src.cfg_ready), 64'(0));
        @(negedge prog_clk);
        start     = 1'b0;
        verify_en = $urandom_range(0, 1);
        check("busy_after_start", 64'(busy), 64'(1));
        check("done_cleared", 64'(done), 64'(0));
        check("crc_err_cleared", 64'(crc_err), 64'(0));

        if (stall) begin
            t = 0;
            while (hs_cnt < 3 && t < 500) begin @(negedge prog_clk); t++; end
            hold = 1'b1;
            t = 0;
            while (!src.cfg_ready && t < 500) begin @(negedge prog_clk); t++; end
            for (int i = 0; i < 5; i++) begin
                check("stall_no_edge", 64'(chain_clk_en), 64'(0));
                check("stall_ready", 64'(src.cfg_ready), 64'(1));
                @(negedge prog_clk);
            end
            hold = 1'b0;
        end

        if (busy_start) begin
            t = 0;
            while (edge_cnt < 30 && t < 500) begin @(negedge prog_clk); t++; end
            start     = 1'b1;
            verify_en = !verify;
            @(negedge prog_clk);
            start = 1'b0;
            check("busy_start_ignored", 64'(busy), 64'(1));
        end

        t = 0;
        while (!done && t < 5000) begin @(negedge prog_clk); t++; end
        if (!done) begin
            check("done_timeout", 64'(done), 64'(1));
            sb.delete();
            src_q.delete();
        end
        repeat (3) @(negedge prog_clk);
        check("done_holds", 64'(done), 64'(1));
        check("busy_low_after", 64'(busy), 64'(0));
        fault_arm = 1'b0;
        gaps      = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int snap;
        repeat (3) @(negedge prog_clk);
        check("rst_ready", 64'(src.cfg_ready), 64'(0));
        check("rst_head", 64'(fpga_head), 64'(0));
        check("rst_clk_en", 64'(chain_clk_en), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_crc_err", 64'(crc_err), 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge prog_clk);

        run_load(T1S, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_load(T1S, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        run_load(T1S, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_load(T1S, 1'b1, 1'b1, 17, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a word shift
        push_words(T1S);
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        t = 0;
        while (edge_cnt < 20 && t < 500) begin @(negedge prog_clk); t++; end
        check("mid_shift_edges", 64'(edge_cnt), 64'(20));
        reset = 1'b1;
        src_q.delete();
        snap = edges_total;
        #1;
        check("mid_rst_clk_en", 64'(chain_clk_en), 64'(0));
        check("mid_rst_ready", 64'(src.cfg_ready), 64'(0));
        check("mid_rst_head", 64'(fpga_head), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_crc_err", 64'(crc_err), 64'(0));
        repeat (3) @(negedge prog_clk);
        reset = 1'b0;
        repeat (3) @(negedge prog_clk);
        check("no_edges_after_rst", 64'(edges_total), 64'(snap));
        run_load(T1S, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        run_load(T1S, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 6; n++) begin
            logic [63:0] s;
            bit v, f;
            s = {32'($urandom), 32'($urandom)};
            v = 1'($urandom_range(0, 1));
            f = v && ($urandom_range(0, 1) == 1);
            run_load(s, v, f, $urandom_range(0, 63), 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge prog_clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
